// File: rtl/router_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// router_pkg : shared widths and header-field helpers for the 1x3 router
// Rev 1.0
// ---------------------------------------------------------------------------
package router_pkg;

  localparam int ROUTER_DATA_W     = 8;
  localparam int ROUTER_FIFO_DEPTH = 16;
  localparam int HDR_LEN_MSB       = 7;
  localparam int HDR_LEN_LSB       = 2;
  localparam int PKT_CNT_W         = 6;
  localparam int HDR_LEN_W         = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  // Bytes still to come after a header: payload length plus the parity byte.
  function automatic logic [PKT_CNT_W-1:0] hdr_to_cnt(input logic [HDR_LEN_W-1:0] len);
    return PKT_CNT_W'(len) + PKT_CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// router_fifo : per-port packet buffer, header-tagged entries, packet-aware
//               idle return on the read side
// Rev 1.0
// ---------------------------------------------------------------------------
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = ROUTER_FIFO_DEPTH,
  parameter int WIDTH = ROUTER_DATA_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH:0]         r_mem [DEPTH];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [PKT_CNT_W-1:0]   r_pkt_cnt;
  logic [WIDTH-1:0]       r_data_out;

  logic                   w_wr_acc;
  logic                   w_rd_acc;
  logic [WIDTH:0]         w_rd_entry;
  logic                   w_rd_is_hdr;

  // Extra pointer MSB distinguishes a full ring from an empty one.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_wr_acc    = write_enb && !full;
  assign w_rd_acc    = read_enb && !empty;
  assign w_rd_entry  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_rd_is_hdr = w_rd_entry[WIDTH];

  // Storage is deliberately left out of reset; the pointers define validity.
  always_ff @(posedge clock) begin
    if (w_wr_acc && !soft_reset) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pkt_cnt  <= '0;
      r_data_out <= '0;
    end else if (soft_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pkt_cnt  <= '0;
      r_data_out <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr   <= r_rd_ptr + PW'(1);
        r_data_out <= w_rd_entry[WIDTH-1:0];
        // A header reloads even mid-packet so a truncated packet cannot stall us.
        if (w_rd_is_hdr) begin
          r_pkt_cnt <= hdr_to_cnt(w_rd_entry[HDR_LEN_MSB:HDR_LEN_LSB]);
        end else if (r_pkt_cnt != '0) begin
          r_pkt_cnt <= r_pkt_cnt - PKT_CNT_W'(1);
        end
      end else if (r_pkt_cnt == '0) begin
        r_data_out <= '0;
      end
    end
  end

  assign data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_router_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_router_fifo : directed vector table plus hand-written corner sequences
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_router_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic       soft_reset;
  logic       write_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic       read_enb;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int checks   = 0;
  int failures = 0;

  router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .read_enb   (read_enb),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       wr;
    logic       lfd;
    logic [7:0] din;
    logic       rd;
    logic [7:0] exp_dout;
    logic       exp_full;
    logic       exp_empty;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] dout,
                           input logic f, input logic e);
    check({name, ".data_out"}, data_out, dout);
    check({name, ".full"},     {7'd0, full},  {7'd0, f});
    check({name, ".empty"},    {7'd0, empty}, {7'd0, e});
  endtask

  // Drive one cycle's inputs, clock it, and sample just after the edge.
  task automatic step(input logic wr, input logic lfd, input logic [7:0] din,
                      input logic rd, input logic srst);
    write_enb  = wr;
    lfd_state  = lfd;
    data_in    = din;
    read_enb   = rd;
    soft_reset = srst;
    @(posedge clock);
    #1;
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    soft_reset = 1'b0;
    lfd_state  = 1'b0;
  endtask

  initial begin
    //              wr    lfd   din    rd    dout   full  empty
    vecs[0]  = '{1'b1, 1'b1, 8'h0D, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'h1F, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h0D, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h1F, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    // empty FIFO with read and write together: only the write lands
    vecs[11] = '{1'b1, 1'b0, 8'h5A, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1};

    reset      = 1'b1;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    lfd_state  = 1'b0;
    data_in    = 8'h00;
    read_enb   = 1'b0;
    #2;
    check_out("por", 8'h00, 1'b0, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].wr, vecs[i].lfd, vecs[i].din, vecs[i].rd, 1'b0);
      check_out($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_full, vecs[i].exp_empty);
    end

    // Asynchronous reset mid-packet, with data_out holding a header byte.
    step(1'b1, 1'b1, 8'h0D, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check_out("hdr_hold", 8'h0D, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_out("async_rst", 8'h00, 1'b0, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_out("post_rst_rd", 8'h00, 1'b0, 1'b1);

    // Full boundary, dropped overflow write, simultaneous access while full.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0, 1'b0);
      if (i == 14) check_out("almost_full", 8'h00, 1'b0, 1'b0);
    end
    check_out("full16", 8'h00, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
    check_out("full_drop", 8'h00, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
    check_out("full_rdwr", 8'hA0, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check($sformatf("drain%0d", i), data_out, 8'hA0 + 8'(i));
    end
    check_out("drained", 8'hAF, 1'b0, 1'b1);

    // soft_reset mid-packet: 3 entries left, pkt_cnt at 2, write requested.
    step(1'b1, 1'b1, 8'h09, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h44, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h66, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check_out("pre_soft", 8'h44, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h99, 1'b0, 1'b1);
    check_out("soft_rst", 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_out("soft_rst_after", 8'h00, 1'b0, 1'b1);

    // Interleaved traffic wrapping the pointers more than twice.
    for (int k = 0; k <= 40; k++) begin
      step((k < 40) ? 1'b1 : 1'b0, 1'b0, 8'h30 + 8'(k), (k > 0) ? 1'b1 : 1'b0, 1'b0);
      if (k > 0) check($sformatf("wrap_d%0d", k), data_out, 8'h30 + 8'(k - 1));
      check($sformatf("wrap_e%0d", k), {7'd0, empty}, (k == 40) ? 8'd1 : 8'd0);
      check($sformatf("wrap_f%0d", k), {7'd0, full}, 8'd0);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check_out("wrap_idle", 8'h00, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
